unidad_control: RTL and testbench
=================================

Name: unidad_control

Overview:
- Microsequencer for the UnidadDatos datapath: registers A, B, C, AC, T, and the ALU with S=add, R=sub.
- Accepts one command per start/done handshake and steps the datapath through it by driving the datapath's read/write/ALU strobes.
- Data flow it relies on:
  - bus1 is the shared tri-state bus.
  - T loads from bus1.
  - ALU computes T (a) op bus1 (b) onto bus3.
  - AC loads from bus3 and drives bus1.
- Sits between a host/test sequencer and UnidadDatos.

Parameters:
- KW, 4, width of repeat count k for the MULK command.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  command request, sampled only in IDLE.
- op  in  2  00 MOV, 01 ADD, 10 SUB, 11 MULK.
- src1  in  2  operand 1 register code: 00 A, 01 B, 10 C, 11 AC.
- src2  in  2  operand 2 register code (ADD/SUB only).
- dst  in  2  destination register code.
- k  in  KW  multiplier for MULK.
- Ra, Rb, Rc, Rac  out  1  bus1 read enables to the datapath.
- Wa, Wb, Wc, Wac, Wt  out  1  register write enables.
- S  out  1  ALU add select.
- R  out  1  ALU subtract select.
- busy  out  1  high from the cycle after accept through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; illegal command.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - All strobes, busy, done and err are 0.
  - Captured fields and the repeat counter are cleared.
  - Reset mid-command abandons the command. Datapath contents are not restored.
- Accept: in IDLE with start=1 at a rising edge, latch op/src1/src2/dst/k. Later input changes are ignored until the next IDLE.
- start outside IDLE is ignored. There is no queuing.
- All outputs decode from state and latched fields only. There is no combinational path from the inputs.
- Invariants, every cycle:
  - At most one of Ra/Rb/Rc/Rac is high.
  - S and R are never both high.
  - At most one of Wa/Wb/Wc/Wac/Wt is high.
  - Every strobe is 0 in IDLE and DONE.
- States: IDLE, XFER, LOADT, EXEC, CLEAR, ACCUM, WB, DONE.
- MOV:
  - dst≠AC: XFER (read src1, write dst) -> DONE.
  - src1==dst is legal and has no net effect.
  - dst=AC: illegal, because AC is written only from the ALU. Go straight to DONE with err=1 and issue no strobes.
- ADD/SUB:
  - LOADT: read src1, Wt.
  - EXEC: read src2, S (ADD) or R (SUB), Wac.
  - WB: Rac, write dst. WB is skipped when dst=AC.
  - Then DONE.
  - src1==src2 is legal. SUB then yields 0.
- MULK (dst = src1*k mod 2^n):
  - LOADT: read src1, Wt.
  - CLEAR: read src1, R, Wac, giving AC=0.
  - ACCUM repeated k times: Rac, S, Wac, giving AC=T+AC.
  - WB if dst≠AC, then DONE.
  - k=0 skips ACCUM entirely.
  - src1=AC is legal because T holds the copy.
- Repeat counter:
  - Loaded with k on entry to CLEAR.
  - Decrements once per ACCUM cycle.
  - Exit ACCUM after the cycle in which count==1.
- Arithmetic wraps modulo 2^n. There is no carry or overflow output.
- Latency from the accept edge to the done cycle:
  - MOV: 2.
  - MOV error: 1.
  - ADD/SUB: 4, or 3 if dst=AC.
  - MULK: 5+k, or 4+k if dst=AC.
- DONE:
  - done=1 for exactly 1 cycle, with busy still 1.
  - Next cycle is IDLE.
  - A new start can be accepted at the edge leaving DONE+1. The earliest is the first IDLE cycle.
- err is 0 except in the DONE cycle of an illegal command.

Test Plan:
- Reset/idle: rst_n low asynchronously mid-ACCUM -> all strobes, busy and done drop to 0 immediately, state is IDLE. After release, with start=0, nothing toggles for 10 cycles.
- MOV: A=7, C=0; op=00, src1=A, dst=C -> one cycle Ra&Wc, done at +2, C=7, A=7. Also op=00, dst=AC -> done with err=1 at +1, no strobes, AC unchanged.
- ADD/SUB: A=7, B=3; ADD src1=A, src2=B, dst=C -> C=10, done at +4. SUB with dst=AC -> AC=4, done at +3, no WB cycle. SUB src1=B, src2=A -> 0xFC (n=8, wraps).
- MULK: B=3, k=5, dst=A -> A=15, done at +10, Wac high in exactly 6 cycles. k=0 -> A=0, done at +5. B=100, k=3 -> A=44 (300 mod 256).
- Handshake: start held high continuously -> back-to-back commands accepted only from IDLE, with one IDLE cycle between done and the next accept. start pulses during busy are ignored. Changing op/src1/src2/dst/k mid-command does not alter the result.
- Invariant monitor, all tests: never two R-strobes together, never S&R together, never two W-strobes together, no strobes in IDLE/DONE.

Source files
------------

// File: rtl/unidad_control.sv
// Microsequencer for the UnidadDatos datapath: accepts MOV/ADD/SUB/MULK commands and
// drives the datapath's bus read, register write and ALU select strobes cycle by cycle.
module unidad_control #(
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [1:0]    src1,
    input  logic [1:0]    src2,
    input  logic [1:0]    dst,
    input  logic [KW-1:0] k,
    output logic          Ra,
    output logic          Rb,
    output logic          Rc,
    output logic          Rac,
    output logic          Wa,
    output logic          Wb,
    output logic          Wc,
    output logic          Wac,
    output logic          Wt,
    output logic          S,
    output logic          R,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MULK = 2'b11;
    localparam logic [1:0] REG_AC  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, XFER, LOADT, EXEC, CLEAR, ACCUM, WB, DONE
    } state_t;

    state_t        state, n_state;
    logic [1:0]    op_q, src1_q, src2_q, dst_q;
    logic [1:0]    n_op, n_src1, n_src2, n_dst;
    logic [KW-1:0] k_q, n_k, cnt, n_cnt;
    logic          ph, n_ph;
    logic          ill_q, n_ill;

    // Register code to one-hot select: bit 0 = A, 1 = B, 2 = C, 3 = AC.
    function automatic logic [3:0] sel(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

    // Strobe pattern for a state, packed as {R, S, Wt, Wac, Wc, Wb, Wa, Rac, Rc, Rb, Ra}.
    function automatic logic [10:0] decode(input state_t s, input logic p, input logic [1:0] o,
                                           input logic [1:0] s1, input logic [1:0] s2,
                                           input logic [1:0] d);
        logic [3:0] rd;
        logic [4:0] wr;
        logic       sa;
        logic       su;
        rd = '0;
        wr = '0;
        sa = 1'b0;
        su = 1'b0;
        case (s)
            XFER: begin
                rd = sel(s1);
                wr = {1'b0, sel(d)};
            end
            LOADT: begin
                rd = sel(s1);
                wr = 5'b10000;
            end
            EXEC: begin
                rd = sel(s2);
                sa = (o == OP_ADD);
                su = (o == OP_SUB);
                wr = 5'b01000;
            end
            CLEAR: begin
                if (p) begin
                    rd = sel(s1);
                    su = 1'b1;
                    wr = 5'b01000;
                end
            end
            ACCUM: begin
                rd = 4'b1000;
                sa = 1'b1;
                wr = 5'b01000;
            end
            WB: begin
                rd = 4'b1000;
                wr = {1'b0, sel(d)};
            end
            default: ;
        endcase
        return {su, sa, wr, rd};
    endfunction

    always_comb begin
        n_state = state;
        n_op    = op_q;
        n_src1  = src1_q;
        n_src2  = src2_q;
        n_dst   = dst_q;
        n_k     = k_q;
        n_cnt   = cnt;
        n_ph    = 1'b0;
        n_ill   = ill_q;
        case (state)
            IDLE: begin
                if (start) begin
                    n_op   = op;
                    n_src1 = src1;
                    n_src2 = src2;
                    n_dst  = dst;
                    n_k    = k;
                    n_ill  = (op == OP_MOV) && (dst == REG_AC);
                    if (n_ill)
                        n_state = DONE;
                    else if (op == OP_MOV)
                        n_state = XFER;
                    else
                        n_state = LOADT;
                end
            end
            XFER:  n_state = DONE;
            LOADT: begin
                if (op_q == OP_MULK) begin
                    n_state = CLEAR;
                    n_cnt   = k_q;
                end else begin
                    n_state = EXEC;
                end
            end
            EXEC:  n_state = (dst_q == REG_AC) ? DONE : WB;
            // CLEAR spends a strobe-free setup cycle before the T-src1 clearing cycle.
            CLEAR: begin
                if (!ph)
                    n_ph = 1'b1;
                else if (cnt == '0)
                    n_state = (dst_q == REG_AC) ? DONE : WB;
                else
                    n_state = ACCUM;
            end
            ACCUM: begin
                n_cnt = cnt - KW'(1);
                if (cnt == KW'(1))
                    n_state = (dst_q == REG_AC) ? DONE : WB;
            end
            WB:    n_state = DONE;
            DONE: begin
                n_state = IDLE;
                n_ill   = 1'b0;
            end
            default: n_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
            k_q    <= '0;
            cnt    <= '0;
            ph     <= 1'b0;
            ill_q  <= 1'b0;
            {R, S, Wt, Wac, Wc, Wb, Wa, Rac, Rc, Rb, Ra} <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= n_state;
            op_q   <= n_op;
            src1_q <= n_src1;
            src2_q <= n_src2;
            dst_q  <= n_dst;
            k_q    <= n_k;
            cnt    <= n_cnt;
            ph     <= n_ph;
            ill_q  <= n_ill;
            // Outputs are registered from the next state so they line up with it.
            {R, S, Wt, Wac, Wc, Wb, Wa, Rac, Rc, Rb, Ra} <=
                decode(n_state, n_ph, n_op, n_src1, n_src2, n_dst);
            busy   <= (n_state != IDLE);
            done   <= (n_state == DONE);
            err    <= (n_state == DONE) && n_ill;
        end
    end

endmodule

// File: tb/tb_unidad_control.sv
// Bench for unidad_control: a small UnidadDatos stand-in driven by the strobes, plus
// an arithmetic reference model of each command's result, latency and AC write count.
module tb_unidad_control;

    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = '0;
    logic [1:0]    src1 = '0;
    logic [1:0]    src2 = '0;
    logic [1:0]    dst = '0;
    logic [KW-1:0] k = '0;
    logic Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R, busy, done, err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    unidad_control #(.KW(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src1(src1), .src2(src2),
        .dst(dst), .k(k), .Ra(Ra), .Rb(Rb), .Rc(Rc), .Rac(Rac), .Wa(Wa), .Wb(Wb),
        .Wc(Wc), .Wac(Wac), .Wt(Wt), .S(S), .R(R), .busy(busy), .done(done), .err(err)
    );

    // Datapath stand-in: A, B, C, AC, T with bus1 and ALU result bus3.
    logic [7:0] rf [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] t_r = 8'd0;
    logic       ld_en = 1'b0;
    logic [1:0] ld_idx = '0;
    logic [7:0] ld_val = '0;
    logic [7:0] bus1, bus3;

    always_comb begin
        bus1 = Ra ? rf[0] : Rb ? rf[1] : Rc ? rf[2] : Rac ? rf[3] : 8'h00;
        bus3 = S ? (t_r + bus1) : (R ? (t_r - bus1) : 8'h00);
    end

    always @(posedge clk) begin
        if (ld_en) begin
            rf[ld_idx] <= ld_val;
        end else begin
            if (Wa)  rf[0] <= bus1;
            if (Wb)  rf[1] <= bus1;
            if (Wc)  rf[2] <= bus1;
            if (Wac) rf[3] <= bus3;
            if (Wt)  t_r   <= bus1;
        end
    end

    logic [7:0] mdl [4];
    logic [7:0] mt;

    wire [10:0] strobes = {Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("one_read", 32'($countones({Ra, Rb, Rc, Rac}) <= 1), 32'd1);
            check("no_s_and_r", 32'(S & R), 32'd0);
            check("one_write", 32'($countones({Wa, Wb, Wc, Wac, Wt}) <= 1), 32'd1);
            if (!busy || done) check("quiet_idle_done", 32'(strobes), 32'd0);
            if (!done) check("err_only_done", 32'(err), 32'd0);
        end
    end

    task automatic load_reg(input int idx, input logic [7:0] val);
        @(negedge clk);
        ld_en = 1'b1;
        ld_idx = 2'(idx);
        ld_val = val;
        mdl[idx] = val;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic set_regs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] ac);
        load_reg(0, a);
        load_reg(1, b);
        load_reg(2, c);
        load_reg(3, ac);
    endtask

    task automatic run_cmd(input logic [1:0] o, input logic [1:0] s1, input logic [1:0] s2,
                           input logic [1:0] d, input logic [KW-1:0] kk, input bit scr);
        int lat, wac, strb, exp_lat, exp_wac;
        bit seen, ill;
        logic [7:0] res;
        @(negedge clk);
        op = o; src1 = s1; src2 = s2; dst = d; k = kk; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0; lat = 0; wac = 0; strb = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (Wac) wac++;
            strb += $countones(strobes);
            if (done) begin
                seen = 1;
                lat = c;
            end else if (scr) begin
                op = 2'($urandom); src1 = 2'($urandom); src2 = 2'($urandom);
                dst = 2'($urandom); k = KW'($urandom); start = 1'($urandom);
            end
        end
        start = 1'b0;
        ill = (o == 2'b00) && (d == 2'b11);
        case (o)
            2'b00:        exp_lat = ill ? 1 : 2;
            2'b01, 2'b10: exp_lat = (d == 2'b11) ? 3 : 4;
            default:      exp_lat = (d == 2'b11) ? 4 + int'(kk) : 5 + int'(kk);
        endcase
        exp_wac = (o == 2'b00) ? 0 : (o == 2'b11) ? int'(kk) + 1 : 1;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", lat, exp_lat);
        check("err", 32'(err), 32'(ill));
        check("wac_cycles", wac, exp_wac);
        if (ill) check("err_no_strobes", strb, 0);
        case (o)
            2'b00: if (!ill) mdl[d] = mdl[s1];
            2'b01: begin mt = mdl[s1]; res = mdl[s1] + mdl[s2]; mdl[3] = res; mdl[d] = res; end
            2'b10: begin mt = mdl[s1]; res = mdl[s1] - mdl[s2]; mdl[3] = res; mdl[d] = res; end
            default: begin
                mt = mdl[s1];
                res = 8'((int'(mt) * int'(kk)) % 256);
                mdl[3] = res;
                mdl[d] = res;
            end
        endcase
        for (int i = 0; i < 4; i++) check($sformatf("reg%0d", i), 32'(rf[i]), 32'(mdl[i]));
        if (o != 2'b00) check("reg_t", 32'(t_r), 32'(mt));
        @(negedge clk);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) mdl[i] = 8'd0;
        mt = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({strobes, busy, done, err}), 32'd0);
        rst_n = 1'b1;

        set_regs(8'd7, 8'd3, 8'd0, 8'd0);
        run_cmd(2'b00, 2'd0, 2'd0, 2'd2, 4'd0, 0);
        check("mov_c_is_7", 32'(rf[2]), 32'd7);
        run_cmd(2'b00, 2'd1, 2'd0, 2'd3, 4'd0, 0);
        run_cmd(2'b01, 2'd0, 2'd1, 2'd2, 4'd0, 0);
        check("add_c_is_10", 32'(rf[2]), 32'd10);
        run_cmd(2'b10, 2'd0, 2'd1, 2'd3, 4'd0, 0);
        check("sub_ac_is_4", 32'(rf[3]), 32'd4);
        run_cmd(2'b10, 2'd1, 2'd0, 2'd2, 4'd0, 0);
        check("sub_wrap_fc", 32'(rf[2]), 32'hFC);
        run_cmd(2'b11, 2'd1, 2'd0, 2'd0, 4'd5, 0);
        check("mulk_a_is_15", 32'(rf[0]), 32'd15);
        run_cmd(2'b11, 2'd1, 2'd0, 2'd0, 4'd0, 0);
        check("mulk_k0_a_is_0", 32'(rf[0]), 32'd0);
        load_reg(1, 8'd100);
        run_cmd(2'b11, 2'd1, 2'd0, 2'd0, 4'd3, 0);
        check("mulk_a_is_44", 32'(rf[0]), 32'd44);
        run_cmd(2'b11, 2'd3, 2'd0, 2'd3, 4'd7, 0);
        run_cmd(2'b10, 2'd2, 2'd2, 2'd1, 4'd0, 0);

        // start held high: accepts only from IDLE, one IDLE cycle between commands
        set_regs(8'd9, 8'd1, 8'd2, 8'd3);
        @(negedge clk);
        op = 2'b00; src1 = 2'd0; dst = 2'd1; start = 1'b1;
        for (int it = 0; it < 3; it++) begin
            int w;
            w = 0;
            while (!done && w < 10) begin
                @(negedge clk);
                w++;
            end
            check("b2b_done", 32'(done), 32'd1);
            mdl[1] = mdl[0];
            check("b2b_reg_b", 32'(rf[1]), 32'(mdl[1]));
            @(negedge clk);
            check("b2b_idle_gap", 32'(busy), 32'd0);
            @(negedge clk);
            check("b2b_accept", 32'(busy), 32'd1);
        end
        start = 1'b0;
        @(negedge clk);
        check("b2b_last_done", 32'(done), 32'd1);
        @(negedge clk);
        check("b2b_final_idle", 32'(busy), 32'd0);

        // asynchronous reset in the middle of ACCUM
        set_regs(8'd1, 8'd2, 8'd3, 8'd4);
        @(negedge clk);
        op = 2'b11; src1 = 2'd1; dst = 2'd0; k = 4'd15; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        check("accum_busy", 32'(busy), 32'd1);
        check("accum_wac", 32'(Wac & S & Rac), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'({strobes, busy, done, err}), 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("quiet_after_reset", 32'({strobes, busy, done, err}), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0)
                set_regs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            run_cmd(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), KW'($urandom), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
